dff_serial_tx: RTL and testbench

DFF_SERIAL_TX -- requirements
Module: dff_serial_tx

---
 rtl/dff_serial_tx.sv | 116 +++++++++++
 tb/tb_dff_serial_tx.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_serial_tx.sv
// Parallel-in, MSB-first serial transmitter with bit-rate tick,
// frame flag, completion pulse and a guaranteed idle gap.
//
// Ports:
//   clk        - clock, rising edge
//   syncResetN - synchronous active-low reset
//   dataIn     - parallel word (WIDTH bits)
//   loadValid  - dataIn holds a word to send
//   loadReady  - block accepts a word (IDLE only)
//   shiftEn    - bit-rate tick
//   serialOut  - registered serial line, idles high
//   frameOut   - registered, high while data bits are on the line
//   done       - registered one-cycle end-of-frame pulse
module dff_serial_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             syncResetN,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             loadValid,
  output logic             loadReady,
  input  logic             shiftEn,
  output logic             serialOut,
  output logic             frameOut,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             so_q, so_d;
  logic             fr_q, fr_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (!syncResetN) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      so_q    <= 1'b1;
      fr_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      so_q    <= so_d;
      fr_q    <= fr_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    so_d    = so_q;
    fr_d    = fr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        so_d = 1'b1;
        fr_d = 1'b0;
        if (loadValid) begin
          // MSB goes on the line at once, tick or not
          state_d = SHIFT;
          shreg_d = dataIn;
          cnt_d   = CW'(WIDTH - 1);
          so_d    = dataIn[WIDTH-1];
          fr_d    = 1'b1;
        end
      end
      SHIFT: begin
        if (shiftEn) begin
          if (cnt_q != '0) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            so_d    = shreg_q[WIDTH-2];
            cnt_d   = cnt_q - 1'b1;
          end else begin
            // LSB held until this tick; line returns to idle
            state_d = GAP;
            so_d    = 1'b1;
            fr_d    = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      GAP: begin
        so_d = 1'b1;
        fr_d = 1'b0;
        if (shiftEn) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        so_d    = 1'b1;
        fr_d    = 1'b0;
      end
    endcase
  end

  assign loadReady = (state_q == IDLE);
  assign serialOut = so_q;
  assign frameOut  = fr_q;
  assign done      = done_q;

endmodule

// File: tb/tb_dff_serial_tx.sv
// Directed self-checking bench for dff_serial_tx (WIDTH=8).
// Inputs change 1ns after the rising edge; outputs sampled there.
module tb_dff_serial_tx;

  logic       clk = 1'b0;
  logic       syncResetN;
  logic [7:0] dataIn;
  logic       loadValid;
  logic       loadReady;
  logic       shiftEn;
  logic       serialOut;
  logic       frameOut;
  logic       done;

  int checks = 0;
  int failures = 0;

  dff_serial_tx #(.WIDTH(8)) dut (
    .clk        (clk),
    .syncResetN (syncResetN),
    .dataIn     (dataIn),
    .loadValid  (loadValid),
    .loadReady  (loadReady),
    .shiftEn    (shiftEn),
    .serialOut  (serialOut),
    .frameOut   (frameOut),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    syncResetN = 1'b0;
    loadValid  = 1'b0;
    shiftEn    = 1'b0;
    dataIn     = 8'h00;
    step();
    step();
    checks++;
    if (serialOut !== 1'b1) begin
      failures++;
      $display("FAIL reset_so got=%b exp=1", serialOut);
    end
    checks++;
    if (frameOut !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_fr_done got=%b%b exp=00", frameOut, done);
    end
    checks++;
    if (loadReady !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", loadReady);
    end
    syncResetN = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] d;
    d = 8'hA5;
    dataIn    = d;
    loadValid = 1'b1;
    shiftEn   = 1'b1;
    step();
    loadValid = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      checks++;
      if (serialOut !== d[i] || frameOut !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL basic_bit%0d got so=%b fr=%b dn=%b exp so=%b fr=1 dn=0",
                 i, serialOut, frameOut, done, d[i]);
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || serialOut !== 1'b1 || frameOut !== 1'b0
        || loadReady !== 1'b0) begin
      failures++;
      $display("FAIL basic_end got dn=%b so=%b fr=%b rdy=%b exp 1 1 0 0",
               done, serialOut, frameOut, loadReady);
    end
    step();
    checks++;
    if (done !== 1'b0 || serialOut !== 1'b1 || loadReady !== 1'b1) begin
      failures++;
      $display("FAIL basic_idle got dn=%b so=%b rdy=%b exp 0 1 1",
               done, serialOut, loadReady);
    end
    shiftEn = 1'b0;
  endtask

  task automatic test_stall();
    logic [7:0] d;
    int ndone;
    d = 8'h81;
    ndone = 0;
    dataIn    = d;
    loadValid = 1'b1;
    shiftEn   = 1'b0;
    step();
    loadValid = 1'b0;
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (serialOut !== d[7-k/4] || frameOut !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL stall_cyc%0d got so=%b fr=%b dn=%b exp so=%b fr=1 dn=0",
                 k, serialOut, frameOut, done, d[7-k/4]);
      end
      shiftEn = ((k + 1) % 4 == 0);
      step();
    end
    if (done === 1'b1) ndone++;
    checks++;
    if (frameOut !== 1'b0 || serialOut !== 1'b1) begin
      failures++;
      $display("FAIL stall_end got fr=%b so=%b exp fr=0 so=1",
               frameOut, serialOut);
    end
    shiftEn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (done === 1'b1) ndone++;
      checks++;
      if (loadReady !== 1'b0 || serialOut !== 1'b1) begin
        failures++;
        $display("FAIL stall_gap%0d got rdy=%b so=%b exp rdy=0 so=1",
                 k, loadReady, serialOut);
      end
    end
    checks++;
    if (ndone != 1) begin
      failures++;
      $display("FAIL stall_done_count got=%0d exp=1", ndone);
    end
    shiftEn = 1'b1;
    step();
    shiftEn = 1'b0;
    checks++;
    if (loadReady !== 1'b1) begin
      failures++;
      $display("FAIL stall_back_idle got rdy=%b exp=1", loadReady);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    logic [7:0] b;
    logic       exp_so;
    logic       exp_dn;
    a = 8'h3C;
    b = 8'hC3;
    dataIn    = a;
    loadValid = 1'b1;
    shiftEn   = 1'b1;
    step();
    dataIn = b;
    for (int k = 0; k <= 18; k++) begin
      exp_dn = (k == 8 || k == 18);
      if (k < 8)       exp_so = a[7-k];
      else if (k < 10) exp_so = 1'b1;
      else if (k < 18) exp_so = b[17-k];
      else             exp_so = 1'b1;
      checks++;
      if (serialOut !== exp_so || done !== exp_dn) begin
        failures++;
        $display("FAIL b2b_cyc%0d got so=%b dn=%b exp so=%b dn=%b",
                 k, serialOut, done, exp_so, exp_dn);
      end
      if (k <= 8) begin
        checks++;
        if (loadReady !== 1'b0) begin
          failures++;
          $display("FAIL b2b_busy%0d got rdy=%b exp=0", k, loadReady);
        end
      end
      if (k == 10) loadValid = 1'b0;
      step();
    end
    shiftEn = 1'b0;
  endtask

  task automatic test_data_change();
    logic [7:0] d;
    d = 8'h5A;
    dataIn    = d;
    loadValid = 1'b1;
    shiftEn   = 1'b1;
    step();
    loadValid = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      dataIn = 8'($urandom);
      checks++;
      if (serialOut !== d[i] || frameOut !== 1'b1) begin
        failures++;
        $display("FAIL chg_bit%0d got so=%b fr=%b exp so=%b fr=1",
                 i, serialOut, frameOut, d[i]);
      end
      step();
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL chg_done got=%b exp=1", done);
    end
    step();
    shiftEn = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic [7:0] d;
    int ndone;
    ndone = 0;
    dataIn    = 8'hFF;
    loadValid = 1'b1;
    shiftEn   = 1'b1;
    step();
    loadValid = 1'b0;
    step();
    step();
    syncResetN = 1'b0;
    #2;
    checks++;
    if (frameOut !== 1'b1 || serialOut !== 1'b1) begin
      failures++;
      $display("FAIL abort_noedge got fr=%b so=%b exp fr=1 so=1",
               frameOut, serialOut);
    end
    step();
    checks++;
    if (serialOut !== 1'b1 || frameOut !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_rst got so=%b fr=%b dn=%b exp 1 0 0",
               serialOut, frameOut, done);
    end
    syncResetN = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      failures++;
      $display("FAIL abort_nodone got=%0d exp=0", ndone);
    end
    d = 8'h0F;
    dataIn    = d;
    loadValid = 1'b1;
    step();
    loadValid = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      checks++;
      if (serialOut !== d[i] || frameOut !== 1'b1) begin
        failures++;
        $display("FAIL reload_bit%0d got so=%b fr=%b exp so=%b fr=1",
                 i, serialOut, frameOut, d[i]);
      end
      step();
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL reload_done got=%b exp=1", done);
    end
    step();
    shiftEn = 1'b0;
  endtask

  task automatic test_reset_vs_load();
    checks++;
    if (loadReady !== 1'b1) begin
      failures++;
      $display("FAIL rvl_pre got rdy=%b exp=1", loadReady);
    end
    dataIn     = 8'hAA;
    loadValid  = 1'b1;
    shiftEn    = 1'b1;
    syncResetN = 1'b0;
    step();
    loadValid  = 1'b0;
    syncResetN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (frameOut !== 1'b0 || serialOut !== 1'b1 || loadReady !== 1'b1) begin
        failures++;
        $display("FAIL rvl_cyc%0d got fr=%b so=%b rdy=%b exp 0 1 1",
                 k, frameOut, serialOut, loadReady);
      end
      step();
    end
    shiftEn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_data_change();
    test_reset_abort();
    test_reset_vs_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
